pump_seq_ctrl: RTL

Pneumatic actuation sequencer that drives the three control-air inputs of a three-chamber peristaltic pump: inlet valve, displacement chamber, outlet valve. It sits between the digital control domain and the chip's pressure manifold, and its outputs map one-to-one onto the pump's `in_air_valve1`, `in_air_dc` and `in_air_valve2` lines. It produces a six-phase peristaltic pattern in either direction, for a programmed number of strokes or continuously. Handshake: start/stop in, busy/done out.

---
 rtl/pump_seq_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pump_seq_ctrl.sv
// Six-phase pneumatic sequencer for a three-chamber peristaltic pump.
// Drives valve1/dc/valve2 air lines for a counted or continuous run.
module pump_seq_ctrl #(
  parameter int PHASE_W  = 16,
  parameter int STROKE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                dir,
  input  logic [PHASE_W-1:0]  phase_len,
  input  logic [STROKE_W-1:0] strokes,
  output logic                air_valve1,
  output logic                air_dc,
  output logic                air_valve2,
  output logic                busy,
  output logic                done,
  output logic [STROKE_W-1:0] stroke_count
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t              state;
  logic [2:0]          phase;
  logic [PHASE_W-1:0]  timer;
  logic [PHASE_W-1:0]  len_q;
  logic [STROKE_W-1:0] strokes_q;
  logic                dir_q;
  logic                stop_pend;
  logic [2:0]          air_q;

  logic [STROKE_W-1:0] cnt_nxt;
  logic                phase_end;
  logic                end_run;

  // Reverse direction swaps the two valve lines.
  function automatic logic [2:0] pat(
    input logic [2:0] ph,
    input logic       d
  );
    logic [2:0] p;
    case (ph)
      3'd0:    p = 3'b100;
      3'd1:    p = 3'b110;
      3'd2:    p = 3'b010;
      3'd3:    p = 3'b011;
      3'd4:    p = 3'b001;
      default: p = 3'b101;
    endcase
    return d ? {p[0], p[1], p[2]} : p;
  endfunction

  always_comb begin
    cnt_nxt   = (&stroke_count) ? stroke_count
                                : stroke_count + 1'b1;
    phase_end = (timer == len_q - PHASE_W'(1));
    end_run   = ((strokes_q != '0) && (cnt_nxt == strokes_q))
                || stop_pend || stop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= '0;
      timer        <= '0;
      len_q        <= PHASE_W'(1);
      strokes_q    <= '0;
      dir_q        <= 1'b0;
      stop_pend    <= 1'b0;
      air_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      stroke_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= RUN;
            dir_q        <= dir;
            len_q        <= (phase_len == '0) ? PHASE_W'(1)
                                              : phase_len;
            strokes_q    <= strokes;
            stop_pend    <= 1'b0;
            stroke_count <= '0;
            phase        <= '0;
            timer        <= '0;
            busy         <= 1'b1;
            air_q        <= pat(3'd0, dir);
          end
        end
        default: begin
          if (stop)
            stop_pend <= 1'b1;
          if (!phase_end) begin
            timer <= timer + 1'b1;
          end else begin
            timer <= '0;
            if (phase != 3'd5) begin
              phase <= phase + 1'b1;
              air_q <= pat(phase + 1'b1, dir_q);
            end else begin
              stroke_count <= cnt_nxt;
              phase        <= '0;
              if (end_run) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
                air_q <= '0;
              end else begin
                air_q <= pat(3'd0, dir_q);
              end
            end
          end
        end
      endcase
    end
  end

  assign air_valve1 = air_q[2];
  assign air_dc     = air_q[1];
  assign air_valve2 = air_q[0];

endmodule
